linear_radix_unit: RTL

Parametrised linear-layer processing unit for the radix-encoded accelerator. It computes LIN_SIZE output neurons in parallel from a stream of bit-serial input activations, most significant plane first, over a runtime-selectable channel count. Each lane keeps a saturating signed accumulator. At the end of an operation the unit emits the raw sums and an optionally ReLU'd, shifted and clamped ACT_BITS activation vector for the next layer. One instance serves one of the LINUNITS slots of the linear stage.

---
 rtl/linear_radix_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/linear_radix_unit.sv
// linear_radix_unit: LIN_SIZE parallel neurons fed by bit-serial activations
// (MSB plane first). Each lane holds a saturating signed accumulator. The
// output activations are quantised combinationally from the accumulators.
module linear_radix_unit #(
  parameter int LIN_SIZE         = 84,
  parameter int LIN_CHANNELS_MAX = 120,
  parameter int ACT_BITS         = 3,
  parameter int WGT_BITS         = 3,
  parameter int SUM_BITS         = 10,
  parameter int OUT_SHIFT        = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [$clog2(LIN_CHANNELS_MAX+1)-1:0]   channels,
  input  logic                                    relu_en,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    act_bit,
  input  logic [LIN_SIZE*WGT_BITS-1:0]            weights,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LIN_SIZE*SUM_BITS-1:0]            sum_o,
  output logic [LIN_SIZE*ACT_BITS-1:0]            act_o,
  output logic                                    ovf
);

  localparam int CW = $clog2(LIN_CHANNELS_MAX+1);
  localparam int PW = (ACT_BITS > 1) ? $clog2(ACT_BITS) : 1;
  localparam int XW = SUM_BITS + 2;
  localparam logic signed [XW-1:0]       SUM_HI  = XW'((1 << (SUM_BITS-1)) - 1);
  localparam logic signed [XW-1:0]       SUM_LO  = XW'(-(1 << (SUM_BITS-1)));
  localparam logic signed [SUM_BITS-1:0] ACT_TOP = SUM_BITS'((1 << ACT_BITS) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                     state, state_nx;
  logic [CW-1:0]              chan_q, chan_cnt, chan_eff;
  logic [PW-1:0]              plane_cnt;
  logic                       relu_q, ovf_q;
  logic signed [SUM_BITS-1:0] acc    [LIN_SIZE];
  logic signed [SUM_BITS-1:0] acc_nx [LIN_SIZE];
  logic [LIN_SIZE-1:0]        lane_sat;
  logic                       beat, last_chan, last_plane, double_acc;

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == DONE);
  assign ovf        = ovf_q;
  assign beat       = in_valid && in_ready;
  assign last_chan  = (chan_cnt == chan_q - CW'(1));
  assign last_plane = (plane_cnt == PW'(ACT_BITS-1));
  assign double_acc = (chan_cnt == '0) && (plane_cnt != '0);
  assign chan_eff   = (channels == '0 || channels > CW'(LIN_CHANNELS_MAX))
                      ? CW'(LIN_CHANNELS_MAX) : channels;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACCUM;
      ACCUM:   if (beat && last_chan && last_plane) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-lane next accumulator: optional doubling at a plane boundary, add the
  // gated weight at extended width, then saturate to the accumulator range.
  always_comb begin
    logic signed [XW-1:0] add_w, base, sum_x;
    lane_sat = '0;
    for (int unsigned i = 0; i < LIN_SIZE; i++) begin
      add_w = act_bit ? XW'($signed(weights[i*WGT_BITS +: WGT_BITS])) : '0;
      base  = double_acc ? (XW'(acc[i]) <<< 1) : XW'(acc[i]);
      sum_x = base + add_w;
      if (sum_x > SUM_HI) begin
        acc_nx[i]   = SUM_HI[SUM_BITS-1:0];
        lane_sat[i] = 1'b1;
      end else if (sum_x < SUM_LO) begin
        acc_nx[i]   = SUM_LO[SUM_BITS-1:0];
        lane_sat[i] = 1'b1;
      end else begin
        acc_nx[i]   = sum_x[SUM_BITS-1:0];
      end
    end
  end

  // Operation setup, accumulation and beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q    <= '0;
      relu_q    <= 1'b0;
      chan_cnt  <= '0;
      plane_cnt <= '0;
      ovf_q     <= 1'b0;
      acc       <= '{default: '0};
    end else if (state == IDLE && start) begin
      chan_q    <= chan_eff;
      relu_q    <= relu_en;
      chan_cnt  <= '0;
      plane_cnt <= '0;
      ovf_q     <= 1'b0;
      acc       <= '{default: '0};
    end else if (beat) begin
      acc <= acc_nx;
      if (|lane_sat) ovf_q <= 1'b1;
      if (last_chan) begin
        chan_cnt  <= '0;
        plane_cnt <= last_plane ? '0 : plane_cnt + PW'(1);
      end else begin
        chan_cnt  <= chan_cnt + CW'(1);
      end
    end
  end

  // Output packing and quantisation: shift, zero negatives, clamp to ACT range.
  always_comb begin
    logic signed [SUM_BITS-1:0] q;
    sum_o = '0;
    act_o = '0;
    for (int unsigned i = 0; i < LIN_SIZE; i++) begin
      sum_o[i*SUM_BITS +: SUM_BITS] = acc[i];
      q = acc[i] >>> OUT_SHIFT;
      if (relu_q && q[SUM_BITS-1]) q = '0;
      if (q[SUM_BITS-1])           act_o[i*ACT_BITS +: ACT_BITS] = '0;
      else if (q > ACT_TOP)        act_o[i*ACT_BITS +: ACT_BITS] = '1;
      else                         act_o[i*ACT_BITS +: ACT_BITS] = q[ACT_BITS-1:0];
    end
  end

endmodule
